// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART Wishbone arbiter.
// Optional timeout support is enabled with UART_ARB_TIMEOUT_EN.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam int          NUM_M_MAX    = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping.
// Purely combinational; returns one-hot pick, its index and a valid flag.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int          j;
  logic [IW-1:0] jw;

  always_comb begin
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    jw    = '0;
    for (int i = 0; i < N; i++) begin
      j  = (int'(ptr) + i) % N;
      jw = IW'(j);
      if (!valid && req[jw]) begin
        valid    = 1'b1;
        pick[jw] = 1'b1;
        idx      = jw;
      end
    end
  end

endmodule

// File: rtl/uart_wb_arbiter.sv
// Round-robin Wishbone B4 classic arbiter in front of the UART slave.
// Define UART_ARB_TIMEOUT_EN to add the hung-slave timeout and timeout_o.
module uart_wb_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_M = 2
`ifdef UART_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic [NUM_M-1:0]    m_cyc_i,
  input  logic [NUM_M-1:0]    m_stb_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [4*NUM_M-1:0]  m_sel_i,
  input  logic [32*NUM_M-1:0] m_adr_i,
  input  logic [32*NUM_M-1:0] m_dat_i,
  output logic [NUM_M-1:0]    m_ack_o,
  output logic [32*NUM_M-1:0] m_dat_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [3:0]          s_sel_o,
  output logic [31:0]         s_adr_o,
  output logic [31:0]         s_dat_o,
  input  logic                s_ack_i,
  input  logic [31:0]         s_dat_i,
  output logic [NUM_M-1:0]    grant_o
`ifdef UART_ARB_TIMEOUT_EN
  , output logic              timeout_o
`endif
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  state_t            state, state_nx;
  logic [IW-1:0]     ptr, gidx, pidx;
  logic [NUM_M-1:0]  grant, req, pick;
  logic              pvalid;
  logic              own_cyc, own_stb;
  logic              kill, fire;

  assign req     = m_cyc_i & m_stb_i;
  assign grant_o = grant;

  uart_rr_pick #(
    .N  (NUM_M),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .pick  (pick),
    .idx   (pidx),
    .valid (pvalid)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (pvalid) state_nx = OWN;
      OWN:  if (!own_cyc) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state <= IDLE;
      ptr   <= '0;
      gidx  <= '0;
      grant <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && pvalid) begin
        grant <= pick;
        gidx  <= pidx;
      end else if (state == OWN && !own_cyc) begin
        grant <= '0;
        ptr   <= (gidx == IW'(NUM_M - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end

  // grant is all-zero outside OWN, so the OR-mux idles the slave bus
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (grant[k]) begin
        own_cyc = own_cyc | m_cyc_i[k];
        own_stb = own_stb | m_stb_i[k];
        s_we_o  = s_we_o  | m_we_i[k];
        s_sel_o = s_sel_o | m_sel_i[4*k +: 4];
        s_adr_o = s_adr_o | m_adr_i[32*k +: 32];
        s_dat_o = s_dat_o | m_dat_i[32*k +: 32];
      end
    end
  end

  assign s_cyc_o = own_cyc;
  assign s_stb_o = own_stb & ~kill;

  always_comb begin
    m_ack_o = '0;
    m_dat_o = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (grant[k]) begin
        m_ack_o[k]          = s_ack_i | fire;
        m_dat_o[32*k +: 32] = fire ? TIMEOUT_DATA : s_dat_i;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 2) > 8) ? $clog2(TIMEOUT + 2) : 8;

  logic [CW-1:0] cnt;

  assign fire      = s_stb_o & ~s_ack_i & (cnt == CW'(TIMEOUT));
  assign timeout_o = fire;

  // kill keeps stb low after a forced termination until the owner leaves
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      cnt  <= '0;
      kill <= 1'b0;
    end else if (state != OWN) begin
      cnt  <= '0;
      kill <= 1'b0;
    end else begin
      if (s_ack_i)
        cnt <= '0;
      else if (s_stb_o)
        cnt <= cnt + 1'b1;
      if (fire)
        kill <= 1'b1;
    end
  end
`else
  assign fire = 1'b0;
  assign kill = 1'b0;
`endif

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Randomized scoreboard bench for uart_wb_arbiter with three masters.
// Timeout scenario is exercised when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_wb_arbiter;

  localparam int          NM = 3;
  localparam logic [31:0] RK = 32'hA5A5_5A5A;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } tx_t;

  typedef struct {
    int  m;
    tx_t t;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [4*NM-1:0]   m_sel;
  logic [32*NM-1:0]  m_adr, m_dat;
  logic [NM-1:0]     m_ack_o;
  logic [32*NM-1:0]  m_dat_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]        s_sel_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic              s_ack;
  logic [31:0]       s_dat;
  logic [NM-1:0]     grant_o;
`ifdef UART_ARB_TIMEOUT_EN
  logic              timeout_o;
`endif

  tx_t  txq[NM][$];
  exp_t expq[$];
  int   checks = 0;
  int   fails  = 0;
  int   ptr_m  = 0;
  bit   no_ack = 0;
  int   wait_n = 0;

  uart_wb_arbiter #(.NUM_M(NM)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .m_cyc_i    (m_cyc),
    .m_stb_i    (m_stb),
    .m_we_i     (m_we),
    .m_sel_i    (m_sel),
    .m_adr_i    (m_adr),
    .m_dat_i    (m_dat),
    .m_ack_o    (m_ack_o),
    .m_dat_o    (m_dat_o),
    .s_cyc_o    (s_cyc_o),
    .s_stb_o    (s_stb_o),
    .s_we_o     (s_we_o),
    .s_sel_o    (s_sel_o),
    .s_adr_o    (s_adr_o),
    .s_dat_o    (s_dat_o),
    .s_ack_i    (s_ack),
    .s_dat_i    (s_dat),
    .grant_o    (grant_o)
`ifdef UART_ARB_TIMEOUT_EN
    , .timeout_o (timeout_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // slave: random 0..2 wait states, read data derived from address
  initial begin
    s_ack = 1'b0;
    s_dat = '0;
    forever begin
      @(posedge clk);
      #2;
      if (s_ack)
        s_ack = 1'b0;
      else if (s_cyc_o && s_stb_o && !no_ack) begin
        if (wait_n == 0) begin
          s_ack  = 1'b1;
          s_dat  = s_adr_o ^ RK;
          wait_n = int'($urandom_range(0, 2));
        end else begin
          wait_n--;
        end
      end
    end
  end

  // monitor: pop expected transfer on every completed slave access
  initial begin
    logic [NM-1:0] prev;
    logic [95:0]   emd;
    exp_t          e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = '0;
        continue;
      end
      if (grant_o != prev && prev != '0)
        chk("dead_cycle", 96'(grant_o), 96'(0));
      prev = grant_o;
      if (s_cyc_o && s_stb_o && s_ack) begin
        if (expq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_xfer: got adr %h expected none", s_adr_o);
        end else begin
          e   = expq.pop_front();
          emd = '0;
          emd[32*e.m +: 32] = e.t.adr ^ RK;
          chk("grant", 96'(grant_o), 96'(1) << e.m);
          chk("s_adr", 96'(s_adr_o), 96'(e.t.adr));
          chk("s_we",  96'(s_we_o),  96'(e.t.we));
          chk("s_sel", 96'(s_sel_o), 96'(e.t.sel));
          chk("s_dat", 96'(s_dat_o), 96'(e.t.dat));
          chk("m_ack", 96'(m_ack_o), 96'(1) << e.m);
          chk("m_dat", m_dat_o, emd);
        end
      end
    end
  end

  task automatic master(int k);
    int n;
    if (txq[k].size() == 0) return;
    @(posedge clk);
    #1;
    for (int j = 0; j < txq[k].size(); j++) begin
      m_cyc[k]          = 1'b1;
      m_stb[k]          = 1'b1;
      m_we[k]           = txq[k][j].we;
      m_sel[4*k +: 4]   = txq[k][j].sel;
      m_adr[32*k +: 32] = txq[k][j].adr;
      m_dat[32*k +: 32] = txq[k][j].dat;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!m_ack_o[k] && n < 500);
      if (!m_ack_o[k]) begin
        checks++;
        fails++;
        $display("FAIL m%0d_ack_wait: got no ack expected ack within 500", k);
      end
      @(posedge clk);
      #1;
    end
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
  endtask

  // reference: owners served in rotation order starting at the pointer
  task automatic run_round();
    int last = -1;
    int k;
    for (int i = 0; i < NM; i++) begin
      k = (ptr_m + i) % NM;
      foreach (txq[k][j]) expq.push_back('{m: k, t: txq[k][j]});
      if (txq[k].size() > 0) last = k;
    end
    if (last >= 0) ptr_m = (last + 1) % NM;
    fork
      master(0);
      master(1);
      master(2);
    join
    for (int i = 0; i < NM; i++) txq[i].delete();
  endtask

  function automatic tx_t mk(logic we, logic [31:0] adr, logic [31:0] dat);
    tx_t t;
    t.we  = we;
    t.sel = 4'hF;
    t.adr = adr;
    t.dat = dat;
    return t;
  endfunction

  function automatic tx_t rnd();
    tx_t t;
    t.we  = 1'($urandom_range(0, 1));
    t.sel = 4'($urandom_range(0, 15));
    t.adr = $urandom;
    t.dat = $urandom;
    return t;
  endfunction

  initial begin
    rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_sel = '0; m_adr = '0; m_dat = '0;
    @(posedge clk);
    #1;
    m_cyc = 3'b011;
    m_stb = 3'b011;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 96'(grant_o), 96'(0));
    chk("rst_s_cyc", 96'(s_cyc_o), 96'(0));
    chk("rst_s_stb", 96'(s_stb_o), 96'(0));
    chk("rst_m_ack", 96'(m_ack_o), 96'(0));
    chk("rst_m_dat", m_dat_o, 96'(0));
    m_cyc = '0;
    m_stb = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    txq[0].push_back(mk(1'b1, 32'h3000_0004, 32'h0000_0055));
    txq[1].push_back(mk(1'b0, 32'h3000_0008, 32'h0));
    fork
      run_round();
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("lat_stb",   96'(s_stb_o), 96'(1));
        chk("lat_grant", 96'(grant_o), 96'(1));
        chk("lat_adr",   96'(s_adr_o), 96'(32'h3000_0004));
      end
    join

    txq[0].push_back(mk(1'b1, 32'h3000_0010, 32'h1234_5678));
    run_round();

    for (int i = 0; i < 3; i++)
      txq[1].push_back(mk(1'b0, 32'h3000_0020 + 32'(4 * i), 32'h0));
    txq[0].push_back(mk(1'b1, 32'h3000_0030, 32'hCAFE_0001));
    run_round();

    txq[2].push_back(mk(1'b1, 32'h3000_0040, 32'h0000_00AA));
    txq[0].push_back(mk(1'b0, 32'h3000_0044, 32'h0));
    run_round();

    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < NM; k++) begin
        int n = int'($urandom_range(0, 3));
        for (int j = 0; j < n; j++) txq[k].push_back(rnd());
      end
      run_round();
    end

`ifdef UART_ARB_TIMEOUT_EN
    begin
      int n = 0;
      no_ack = 1'b1;
      @(posedge clk);
      #1;
      m_cyc[0] = 1'b1;
      m_stb[0] = 1'b1;
      m_adr[31:0] = 32'h3000_00FC;
      do begin
        @(negedge clk);
        n++;
      end while (!m_ack_o[0] && n < 400);
      chk("to_ack",   96'(m_ack_o), 96'(1));
      chk("to_dat",   96'(m_dat_o[31:0]), 96'(32'hDEAD_BEEF));
      chk("to_pulse", 96'(timeout_o), 96'(1));
      chk("to_delay", 96'(n >= 255 && n <= 258), 96'(1));
      @(negedge clk);
      chk("to_stb_drop", 96'(s_stb_o), 96'(0));
      chk("to_grant_kept", 96'(grant_o), 96'(1));
      @(posedge clk);
      #1;
      m_cyc[0] = 1'b0;
      m_stb[0] = 1'b0;
      no_ack = 1'b0;
    end
`endif

    repeat (5) @(posedge clk);
    chk("exp_queue_empty", 96'(expq.size()), 96'(0));
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
